// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode encoding and LED pattern decode helpers for led_sequencer
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    // Per-bit decoders so the caller can size the LED bus by its own parameter
    function automatic logic onehot_bit(input int pos, input int idx);
        return (idx == pos);
    endfunction

    function automatic logic fill_bit(input int pos, input int idx);
        return (idx <= pos);
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// rtl/led_step_timer.sv - holdable prescaler producing one tick every STEP_CYCLES unheld cycles
module led_step_timer #(
    parameter int STEP_CYCLES = 5000000,
    parameter int CNT_W       = 32
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic HOLD,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_d;

    assign tick = !HOLD && (timer_q == LAST);

    always_comb begin
        timer_d = timer_q;
        if (!HOLD) begin
            timer_d = tick ? '0 : timer_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - N-LED pattern sequencer (up/down/bounce/fill) with hold and step/wrap strobes
// Optional fading trail on the previous LED when LED_SEQ_TRAIL_EN is defined.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LED       = 8,
    parameter int STEP_CYCLES = 5000000,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             HOLD,
    input  logic [1:0]       MODE,
    output logic [N_LED-1:0] led,
    output logic             step_pulse,
    output logic             wrap_pulse
);

    localparam int              PW         = $clog2(N_LED);
    localparam logic [PW-1:0]   POS_LAST   = PW'(N_LED - 1);
    localparam logic [PW-1:0]   POS_PENULT = PW'(N_LED - 2);
    localparam logic [N_LED-1:0] LED_RST   = N_LED'(1);

    logic             tick;
    logic             mode_chg;
    logic [PW-1:0]    pos_q,  pos_d;
    logic             dir_q,  dir_d;
    mode_e            mode_q, mode_d;
    logic [N_LED-1:0] pat_q,  pat_d;
    logic             step_q;
    logic             wrap_q, wrap_d;

    led_step_timer #(
        .STEP_CYCLES (STEP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .CLK   (CLK),
        .RST_N (RST_N),
        .HOLD  (HOLD),
        .tick  (tick)
    );

    assign mode_chg = (mode_e'(MODE) != mode_q);

    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        if (tick) begin
            if (mode_chg) begin
                // A new mode always restarts from LED 0 without signalling a wrap
                mode_d = mode_e'(MODE);
                pos_d  = '0;
                dir_d  = 1'b0;
            end else begin
                case (mode_q)
                    MODE_DOWN: pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
                    MODE_BOUNCE: begin
                        if (!dir_q) begin
                            if (pos_q == POS_LAST) begin
                                dir_d = 1'b1;
                                pos_d = POS_PENULT;
                            end else begin
                                pos_d = pos_q + 1'b1;
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_d = 1'b0;
                                pos_d = PW'(1);
                            end else begin
                                pos_d = pos_q - 1'b1;
                            end
                        end
                    end
                    default:   pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
                endcase
                wrap_d = (mode_q == MODE_DOWN) ? (pos_d == POS_LAST) : (pos_d == '0);
            end
        end
    end

    always_comb begin
        pat_d = '0;
        for (int i = 0; i < N_LED; i++) begin
            pat_d[i] = (mode_d == MODE_FILL) ? fill_bit(int'(pos_d), i)
                                             : onehot_bit(int'(pos_d), i);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pos_q  <= '0;
            dir_q  <= 1'b0;
            mode_q <= MODE_UP;
            pat_q  <= LED_RST;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            pat_q  <= pat_d;
            step_q <= tick;
            wrap_q <= wrap_d;
        end
    end

    assign step_pulse = step_q;
    assign wrap_pulse = wrap_q;

`ifdef LED_SEQ_TRAIL_EN
    logic [1:0]       pwm_q,   pwm_d;
    logic [PW-1:0]    prev_q,  prev_d;
    logic             trail_q, trail_d;
    logic [N_LED-1:0] led_q,   led_d;

    assign pwm_d = pwm_q + 1'b1;

    always_comb begin
        prev_d  = prev_q;
        trail_d = trail_q;
        if (tick) begin
            trail_d = !mode_chg;
            prev_d  = pos_q;
        end
    end

    // Trail dims the previous head to 25% duty; fill mode already lights it solidly
    always_comb begin
        led_d = pat_d;
        for (int i = 0; i < N_LED; i++) begin
            if (trail_d && (mode_d != MODE_FILL) && (pwm_d == 2'd0) && onehot_bit(int'(prev_d), i)) begin
                led_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pwm_q   <= 2'd0;
            prev_q  <= '0;
            trail_q <= 1'b0;
            led_q   <= LED_RST;
        end else begin
            pwm_q   <= pwm_d;
            prev_q  <= prev_d;
            trail_q <= trail_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;
`else
    assign led = pat_q;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - directed self-checking bench for led_sequencer (N_LED=8, STEP_CYCLES=4)
module tb_led_sequencer;

    localparam int N  = 8;
    localparam int SC = 4;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         HOLD;
    logic [1:0]   MODE;
    logic [N-1:0] led;
    logic         step_pulse;
    logic         wrap_pulse;

    logic         RST1_N;
    logic [3:0]   led1;
    logic         step1;
    logic         wrap1;

    int checks = 0;
    int errors = 0;

    led_sequencer #(.N_LED(N), .STEP_CYCLES(SC), .CNT_W(32)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .HOLD       (HOLD),
        .MODE       (MODE),
        .led        (led),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse)
    );

    led_sequencer #(.N_LED(4), .STEP_CYCLES(1), .CNT_W(32)) dut1 (
        .CLK        (CLK),
        .RST_N      (RST1_N),
        .HOLD       (1'b0),
        .MODE       (2'd0),
        .led        (led1),
        .step_pulse (step1),
        .wrap_pulse (wrap1)
    );

    always #5 CLK = ~CLK;

    task automatic edges(input int n);
        repeat (n) @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset;
        RST_N = 1'b0; RST1_N = 1'b0; HOLD = 1'b0; MODE = 2'd0;
        edges(2);
        checks++;
        if ({led, step_pulse, wrap_pulse} !== {8'h01, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got led=%h step=%b wrap=%b exp led=01 step=0 wrap=0", led, step_pulse, wrap_pulse);
        end
        checks++;
        if ({led1, step1, wrap1} !== {4'h1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state_sc1 got led=%h step=%b wrap=%b exp led=1 step=0 wrap=0", led1, step1, wrap1);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_up;
        logic [7:0] exp;
        for (int k = 1; k <= 8; k++) begin
            edges(SC - 1);
            checks++;
            if ({led, step_pulse} !== {8'(1 << ((k - 1) % 8)), 1'b0}) begin
                errors++;
                $display("FAIL up_idle k=%0d got led=%h step=%b exp led=%h step=0", k, led, step_pulse, 8'(1 << ((k - 1) % 8)));
            end
            edges(1);
            exp = 8'(1 << (k % 8));
            checks++;
            if ({led, step_pulse, wrap_pulse} !== {exp, 1'b1, (k == 8)}) begin
                errors++;
                $display("FAIL up_step k=%0d got led=%h step=%b wrap=%b exp led=%h step=1 wrap=%b", k, led, step_pulse, wrap_pulse, exp, (k == 8));
            end
        end
    endtask

    task automatic test_bounce;
        int bpos [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        logic [7:0] exp;
        MODE = 2'd2;
        edges(SC);
        checks++;
        if ({led, step_pulse, wrap_pulse} !== {8'h01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL bounce_enter got led=%h step=%b wrap=%b exp led=01 step=1 wrap=0", led, step_pulse, wrap_pulse);
        end
        for (int k = 0; k < 15; k++) begin
            edges(SC);
            exp = 8'(1 << bpos[k]);
            checks++;
            if ({led, step_pulse, wrap_pulse} !== {exp, 1'b1, (bpos[k] == 0)}) begin
                errors++;
                $display("FAIL bounce k=%0d got led=%h step=%b wrap=%b exp led=%h step=1 wrap=%b", k, led, step_pulse, wrap_pulse, exp, (bpos[k] == 0));
            end
        end
    endtask

    task automatic test_fill;
        logic [7:0] exp;
        MODE = 2'd3;
        edges(SC);
        checks++;
        if ({led, step_pulse, wrap_pulse} !== {8'h01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fill_enter got led=%h step=%b wrap=%b exp led=01 step=1 wrap=0", led, step_pulse, wrap_pulse);
        end
        for (int k = 1; k <= 8; k++) begin
            edges(SC);
            exp = 8'((1 << ((k % 8) + 1)) - 1);
            checks++;
            if ({led, step_pulse, wrap_pulse} !== {exp, 1'b1, (k == 8)}) begin
                errors++;
                $display("FAIL fill k=%0d got led=%h step=%b wrap=%b exp led=%h step=1 wrap=%b", k, led, step_pulse, wrap_pulse, exp, (k == 8));
            end
        end
    endtask

    task automatic test_hold;
        edges(2);
        HOLD = 1'b1;
        for (int k = 0; k < 10; k++) begin
            edges(1);
            checks++;
            if ({led, step_pulse, wrap_pulse} !== {8'h01, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL hold_frozen k=%0d got led=%h step=%b wrap=%b exp led=01 step=0 wrap=0", k, led, step_pulse, wrap_pulse);
            end
        end
        HOLD = 1'b0;
        edges(1);
        checks++;
        if ({led, step_pulse} !== {8'h01, 1'b0}) begin
            errors++;
            $display("FAIL hold_release1 got led=%h step=%b exp led=01 step=0", led, step_pulse);
        end
        edges(1);
        checks++;
        if ({led, step_pulse, wrap_pulse} !== {8'h03, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL hold_release2 got led=%h step=%b wrap=%b exp led=03 step=1 wrap=0", led, step_pulse, wrap_pulse);
        end
    endtask

    task automatic test_mode_change;
        logic [7:0] seq [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01, 8'h80, 8'h40};
        logic       wseq [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        MODE = 2'd0;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) begin
                edges(2);
                MODE = 2'd1;
                edges(2);
            end else begin
                edges(SC);
            end
            checks++;
            if ({led, step_pulse, wrap_pulse} !== {seq[k], 1'b1, wseq[k]}) begin
                errors++;
                $display("FAIL mode_change k=%0d got led=%h step=%b wrap=%b exp led=%h step=1 wrap=%b", k, led, step_pulse, wrap_pulse, seq[k], wseq[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        edges(SC);
        edges(SC);
        checks++;
        if ({led, step_pulse} !== {8'h10, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid_setup got led=%h step=%b exp led=10 step=1", led, step_pulse);
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if ({led, step_pulse, wrap_pulse} !== {8'h01, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_async got led=%h step=%b wrap=%b exp led=01 step=0 wrap=0", led, step_pulse, wrap_pulse);
        end
        MODE = 2'd0;
        @(negedge CLK);
        RST_N = 1'b1;
        edges(SC - 1);
        checks++;
        if ({led, step_pulse, wrap_pulse} !== {8'h01, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_wait got led=%h step=%b wrap=%b exp led=01 step=0 wrap=0", led, step_pulse, wrap_pulse);
        end
        edges(1);
        checks++;
        if ({led, step_pulse, wrap_pulse} !== {8'h02, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_first_step got led=%h step=%b wrap=%b exp led=02 step=1 wrap=0", led, step_pulse, wrap_pulse);
        end
    endtask

    task automatic test_step1;
        RST1_N = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            edges(1);
            checks++;
            if ({led1, step1, wrap1} !== {4'(1 << (k % 4)), 1'b1, (k % 4 == 0)}) begin
                errors++;
                $display("FAIL step_cycles1 k=%0d got led=%h step=%b wrap=%b exp led=%h step=1 wrap=%b", k, led1, step1, wrap1, 4'(1 << (k % 4)), (k % 4 == 0));
            end
        end
    endtask

    initial begin
        test_reset;
        test_up;
        test_bounce;
        test_fill;
        test_hold;
        test_mode_change;
        test_reset_mid;
        test_step1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern sequencer, the next generation of the fixed 8-LED chaser. A prescaler divides CLK into step ticks, and a position counter is decoded into one of four patterns on an N-wide LED bus. It adds runtime mode select, a hold input, and step/wrap strobes for the music and display logic.

## Interface
- N_LED, default 8: LED count; legal range ≥2.
- STEP_CYCLES, default 5000000: CLK cycles per step; legal range ≥1.
- CNT_W, default 32: prescaler width; requires 2^CNT_W > STEP_CYCLES.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- HOLD  in  1  freeze sequencer while high.
- MODE  in  2  pattern select: 0 up, 1 down, 2 bounce, 3 fill.
- led  out  N_LED  LED drive, registered, 1 = on.
- step_pulse  out  1  one-cycle strobe on each step.
- wrap_pulse  out  1  one-cycle strobe when a sequence restarts.

## Operation
- State registers:
  - timer[CNT_W]
  - pos[$clog2(N_LED)]
  - dir (0 = rising)
  - mode_q[2]
- Reset values: timer=0, pos=0, dir=0, mode_q=0, led=1 (bit 0), step_pulse=0, wrap_pulse=0.
- Prescaler, when HOLD=0: timer increments each cycle. At timer==STEP_CYCLES-1, timer returns to 0 and a step occurs.
- HOLD=1:
  - timer, pos, dir, mode_q and led are all held.
  - step_pulse and wrap_pulse are 0.
  - On release, counting resumes from the held timer value.
- On each step, MODE is sampled.
  - If MODE≠mode_q: mode_q←MODE, pos←0, dir←0, wrap_pulse=0.
  - Otherwise pos advances according to mode_q.
- Mode 0, up: pos+1. N_LED-1 wraps to 0. led = one-hot(pos).
- Mode 1, down: pos-1. 0 wraps to N_LED-1. led = one-hot(pos).
- Mode 2, bounce: pos moves in direction dir.
  - At pos=N_LED-1 with dir=0: dir←1, pos←N_LED-2.
  - At pos=0 with dir=1: dir←0, pos←1.
  - Each endpoint is shown for exactly one step. Period is 2·N_LED-2 steps.
  - led = one-hot(pos).
- Mode 3, fill: pos+1, wrapping to 0. led = (2^(pos+1))-1, i.e. pos+1 low bits set.
- wrap_pulse: asserted on a step whose new pos is 0, in an unchanged mode.
  - Mode 1 exception: asserted when new pos is N_LED-1, at the wrap from 0.
- Mode change and HOLD together: HOLD wins. MODE is not sampled during HOLD.

## Timing
- Steps occur every STEP_CYCLES unheld cycles. The first step is STEP_CYCLES cycles after RST_N deasserts.
- pos, led, step_pulse and wrap_pulse all update on the same CLK edge. Latency from terminal count to led change is 1 edge.
- STEP_CYCLES=1: a step occurs on every unheld cycle. step_pulse stays high continuously.
- RST_N assertion mid-sequence: all outputs return to reset values immediately (asynchronously). The first step after release again waits a full STEP_CYCLES.

## Configuration
- LED_SEQ_TRAIL_EN defined:
  - Adds a 2-bit free-running pwm counter. It resets to 0 and runs even during HOLD.
  - Adds a prev_pos register, loaded with the old pos on each step.
  - In modes 0–2, led[prev_pos] is additionally on when pwm==0 (25% duty).
  - The trail is suppressed after reset and after a mode change until the next step.
  - Mode 3 is unaffected.
- LED_SEQ_TRAIL_EN undefined: head LED only. No pwm or prev_pos logic is present.

## Structure
- Package led_seq_pkg:
  - mode constants MODE_UP=2'd0, MODE_DOWN=2'd1, MODE_BOUNCE=2'd2, MODE_FILL=2'd3
  - function onehot/fill decode helpers
- Sub-module led_step_timer, parameters STEP_CYCLES and CNT_W.
  - Inputs: CLK, RST_N, HOLD.
  - Output: tick (the step condition).
- Pattern FSM and output registers live in led_sequencer.

## Test plan
Benches use N_LED=8 and STEP_CYCLES=4.
- Reset, then MODE=0 for 40 cycles:
  - led=0x01 after reset, then 0x02 at cycle 4, 0x04 at cycle 8, and so on up to 0x80.
  - Next led is 0x01 with wrap_pulse=1.
- MODE=2, run 14 steps:
  - led visits 0x01, 0x02 … 0x80, then 0x40 … 0x01.
  - 0x80 and 0x01 each appear once per turn. wrap_pulse on return to 0x01.
- MODE=3:
  - led is 0x01, 0x03, 0x07 … 0xFF, then 0x01 with wrap_pulse=1.
- HOLD=1 for 10 cycles at timer=2:
  - led frozen, no strobes.
  - After release, the step occurs exactly 2 cycles later.
- MODE changes 0→1 mid-step while led=0x08:
  - The change applies at the next step: led=0x01, wrap_pulse=0.
  - Following steps give 0x80, then 0x40, with wrap_pulse=1 at 0x80.
- RST_N pulsed low mid-step while led=0x10:
  - led=0x01 and strobes=0 immediately.
  - The next step comes 4 cycles after release.
  - With LED_SEQ_TRAIL_EN: no trail LED until the first step.
